// File: rtl/dram_pkg.sv
// Shared DRAM command encodings and controller FSM states.
package dram_pkg;

   typedef enum logic [1:0] {
      CMD_ACT = 2'b00,
      CMD_COL = 2'b01,
      CMD_REF = 2'b10,
      CMD_PRE = 2'b11
   } dram_cmd_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StRelease
   } dram_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh-interval timer: raises a sticky refresh_flag after T_REFI enabled cycles.
// `DRAM_REF_OVERRUN_EN adds refresh_overrun, set when a second interval passes unserviced.
module dram_refresh_timer #(
   parameter int unsigned T_REFI = 64
) (
   input  logic clk,
   input  logic rst_b,
   input  logic count_en,
   input  logic reload,
   output logic refresh_flag
`ifdef DRAM_REF_OVERRUN_EN
   ,
   output logic refresh_overrun
`endif
);

   localparam int unsigned CntW = $clog2(T_REFI) + 1;
   localparam logic [CntW-1:0] CntInit = CntW'(T_REFI - 1);

   logic [CntW-1:0] cnt_q;
   logic            flag_q;

   // Reload has priority so an expiry on the REF ack edge is absorbed.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         cnt_q  <= CntInit;
         flag_q <= 1'b0;
      end else if (reload) begin
         cnt_q  <= CntInit;
         flag_q <= 1'b0;
      end else if (count_en) begin
         if (cnt_q == '0) begin
            flag_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   assign refresh_flag = flag_q;

`ifdef DRAM_REF_OVERRUN_EN
   logic [CntW-1:0] ovr_cnt_q;
   logic            ovr_q;

   // Second interval only runs while the first one is pending.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         ovr_cnt_q <= CntInit;
         ovr_q     <= 1'b0;
      end else if (reload || !flag_q) begin
         ovr_cnt_q <= CntInit;
      end else if (count_en) begin
         if (ovr_cnt_q == '0) begin
            ovr_q <= 1'b1;
         end else begin
            ovr_cnt_q <= ovr_cnt_q - CntW'(1);
         end
      end
   end

   assign refresh_overrun = ovr_q;
`endif

endmodule

// File: rtl/dram_cmd_timing.sv
// DRAM command timing controller: issues one command, waits its timing parameter, then acks.
// `DRAM_REF_OVERRUN_EN adds the refresh_overrun output.
module dram_cmd_timing
   import dram_pkg::*;
#(
   parameter int unsigned T_RCD  = 3,
   parameter int unsigned T_CCD  = 2,
   parameter int unsigned T_RP   = 3,
   parameter int unsigned T_RFC  = 8,
   parameter int unsigned T_REFI = 64
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       cmd_req,
   input  logic [1:0] cmd,
   input  logic       count_en,
   output logic       cmd_ack,
   output logic       refresh_flag,
   output logic       dram_cmd_valid,
   output logic [1:0] dram_cmd,
   output logic       busy
`ifdef DRAM_REF_OVERRUN_EN
   ,
   output logic       refresh_overrun
`endif
);

   localparam int unsigned TMax  = max_u(max_u(T_RCD, T_CCD), max_u(T_RP, T_RFC));
   localparam int unsigned WaitW = $clog2(TMax) + 1;

   if (T_RCD == 0 || T_CCD == 0 || T_RP == 0 || T_RFC == 0 || T_REFI == 0) begin : g_param_check
      $error("dram_cmd_timing: every timing parameter must be at least 1");
   end

   dram_state_e      state_q;
   dram_cmd_e        cmd_q;
   logic [WaitW-1:0] wait_q;
   logic [WaitW-1:0] t_sel;
   logic             ack_q;
   logic             valid_q;
   logic             ack_set;
   logic             ref_done;

   // ack is asserted in the final WAIT cycle, T_x cycles after the issue strobe.
   always_comb begin
      t_sel = WaitW'(T_RCD);
      unique case (cmd_q)
         CMD_ACT: t_sel = WaitW'(T_RCD);
         CMD_COL: t_sel = WaitW'(T_CCD);
         CMD_PRE: t_sel = WaitW'(T_RP);
         CMD_REF: t_sel = WaitW'(T_RFC);
      endcase
      ack_set  = ((state_q == StIssue) && (t_sel == WaitW'(1))) ||
                 ((state_q == StWait) && (wait_q == WaitW'(1)));
      ref_done = ack_set && (cmd_q == CMD_REF);
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q <= StIdle;
         cmd_q   <= CMD_ACT;
         wait_q  <= '0;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         ack_q   <= ack_set;
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_req) begin
                  cmd_q   <= dram_cmd_e'(cmd);
                  valid_q <= 1'b1;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               wait_q  <= t_sel - WaitW'(1);
               state_q <= StWait;
            end
            StWait: begin
               if (wait_q == '0) begin
                  state_q <= StRelease;
               end else begin
                  wait_q <= wait_q - WaitW'(1);
               end
            end
            StRelease: begin
               if (!cmd_req) begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

   assign cmd_ack        = ack_q;
   assign dram_cmd_valid = valid_q;
   assign dram_cmd       = cmd_q;
   assign busy           = (state_q != StIdle);

   dram_refresh_timer #(
      .T_REFI(T_REFI)
   ) u_refresh_timer (
      .clk          (clk),
      .rst_b        (rst_b),
      .count_en     (count_en),
      .reload       (ref_done),
      .refresh_flag (refresh_flag)
`ifdef DRAM_REF_OVERRUN_EN
      ,
      .refresh_overrun(refresh_overrun)
`endif
   );

endmodule

// File: doc/dram_cmd_timing.md
DRAM_CMD_TIMING -- requirements
Module: dram_cmd_timing

Interface
REQ-001 SHALL have parameter T_RCD, default 3: wait cycles after ACTIVATE (cmd 2'b00) before ack.
REQ-002 SHALL have parameter T_CCD, default 2: wait cycles after column access (cmd 2'b01).
REQ-003 SHALL have parameter T_RP, default 3: wait cycles after PRECHARGE (cmd 2'b11).
REQ-004 SHALL have parameter T_RFC, default 8: wait cycles after REFRESH (cmd 2'b10).
REQ-005 SHALL have parameter T_REFI, default 64: refresh interval in counted cycles.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_b, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port cmd_req, input, 1: controller command request.
REQ-009 SHALL have port cmd, input, 2: command code (00 ACT, 01 COL, 11 PRE, 10 REF).
REQ-010 SHALL have port count_en, input, 1: refresh-interval count enable.
REQ-011 SHALL have port cmd_ack, output, 1: one-cycle command-complete pulse.
REQ-012 SHALL have port refresh_flag, output, 1: sticky refresh-due indication.
REQ-013 SHALL have port dram_cmd_valid, output, 1: one-cycle command issue strobe to the device.
REQ-014 SHALL have port dram_cmd, output, 2: issued command code, held from issue until ack.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RELEASE.
REQ-017 IDLE with cmd_req=1 at edge N SHALL latch cmd and enter ISSUE; dram_cmd_valid=1 during cycle N+1 only.
REQ-018 ISSUE SHALL load the wait counter with the parameter selected by the latched cmd and enter WAIT.
REQ-019 cmd_ack SHALL be 1 for exactly one cycle, exactly T_x cycles after the dram_cmd_valid cycle; the FSM then enters RELEASE.
REQ-020 RELEASE SHALL return to IDLE only once cmd_req=0 is sampled; no new command is accepted in RELEASE.
REQ-021 Changes on cmd or cmd_req during ISSUE or WAIT SHALL be ignored.
REQ-022 Refresh counter SHALL load T_REFI-1 and decrement only when count_en=1; on reaching 0 it SHALL set refresh_flag and hold at 0.
REQ-023 refresh_flag SHALL clear, and the counter SHALL reload T_REFI-1, on the cmd_ack cycle of a REF command; an unsolicited REF SHALL also reload.
REQ-024 Counter expiry coinciding with a REF ack SHALL resolve in favour of the ack: flag cleared, counter reloaded.
REQ-025 Wait and refresh counters SHALL be sized with $clog2 of their largest parameter plus 1 and SHALL never wrap.
REQ-026 Every timing parameter SHALL be >=1; elaboration SHALL fail otherwise.

Reset
REQ-027 rst_b=1 SHALL immediately force IDLE; cmd_ack, refresh_flag, dram_cmd_valid and busy SHALL be 0; dram_cmd SHALL be 2'b00; the refresh counter SHALL be T_REFI-1.
REQ-028 Reset during WAIT SHALL abort the command with no ack after release.

Configuration
REQ-029 With DRAM_REF_OVERRUN_EN defined, the block SHALL have output refresh_overrun (1 bit, reset 0), set sticky when a second T_REFI interval elapses while refresh_flag=1, cleared only by reset.
REQ-030 Without DRAM_REF_OVERRUN_EN, the port and its logic SHALL be absent.

Structure
REQ-031 Command encodings (CMD_ACT, CMD_COL, CMD_REF, CMD_PRE) and FSM state encodings SHALL reside in shared package dram_pkg, also used by the controller FSM.
REQ-032 The refresh-interval counter SHALL be the sub-module dram_refresh_timer; the remainder SHALL stay flat.

Verification (T_RCD=3, T_CCD=2, T_RP=3, T_RFC=8, T_REFI=64)
REQ-033 cmd_req=1, cmd=00 at edge 0 -> dram_cmd_valid in cycle 1, cmd_ack in cycle 4, busy=1 in cycles 1-4.
REQ-034 Sequence ACT, COL, PRE with cmd_req dropped one cycle after each ack -> acks 3, 2 and 3 cycles after their strobes; dram_cmd 00/01/11.
REQ-035 count_en=1 for 64 cycles -> refresh_flag=1; REF issued -> flag clears on the ack cycle (8 cycles after strobe).
REQ-036 count_en=0 for 100 cycles, then 1 -> flag only after 64 enabled cycles.
REQ-037 rst_b pulse in WAIT of a REF -> all outputs 0 immediately; no cmd_ack; refresh counter = 63.
REQ-038 With DRAM_REF_OVERRUN_EN: no REF for 128 enabled cycles -> refresh_overrun=1 and stays set after a later REF.
